// File: rtl/bep_frame_sequencer_if.sv
// Signal bundle between bep_frame_sequencer, the serial front end, the decoder and the frame consumer.
// The master modport is the sequencer's view of these signals.
interface bep_frame_sequencer_if #(
   parameter int unsigned CNT_W = 11
);
   logic             serial_clock_raw;
   logic             serial_data_raw;
   logic             decoder_valid;
   logic             shift_strobe;
   logic             shift_data;
   logic             decoder_clear;
   logic             frame_ready;
   logic             frame_ack;
   logic [CNT_W-1:0] bit_count;
   logic             err_timeout;
   logic             err_overflow;
   logic             err_overrun;
   logic [7:0]       frame_count;

   modport master (
      input  serial_clock_raw, serial_data_raw, decoder_valid, frame_ack,
      output shift_strobe, shift_data, decoder_clear, frame_ready, bit_count,
             err_timeout, err_overflow, err_overrun, frame_count
   );

   modport slave (
      output serial_clock_raw, serial_data_raw, decoder_valid, frame_ack,
      input  shift_strobe, shift_data, decoder_clear, frame_ready, bit_count,
             err_timeout, err_overflow, err_overrun, frame_count
   );
endinterface

// File: rtl/bep_frame_sequencer.sv
// BEP frame capture sequencer: synchronises the serial lines, strobes the decoder and hands frames out.
// Optional FRAME_COUNTER_EN: count acknowledged frames on frame_count (tied to 0 otherwise).
module bep_frame_sequencer #(
   parameter int unsigned FRAME_BITS = 192,
   parameter int unsigned MAX_BITS   = 1024,
   parameter int unsigned GAP_CYCLES = 4096,
   parameter int unsigned CNT_W      = 11
) (
   input  logic                  clock,
   input  logic                  reset,
   bep_frame_sequencer_if.master bus
);
   localparam int unsigned GAP_W = $clog2(GAP_CYCLES);

   typedef enum logic [1:0] {
      S_FLUSH,
      S_IDLE,
      S_RECEIVE,
      S_HOLD
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_sck_s1, r_sck_s2, r_sck_s3;
   logic             r_sd_s1, r_sd_s2;
   logic             w_edge;
   logic             r_shift_strobe, w_strobe_nxt;
   logic             r_shift_data;
   logic [CNT_W-1:0] r_bit_count, w_bit_cnt_nxt;
   logic [GAP_W-1:0] r_gap, w_gap_nxt;
   logic             r_err_timeout, r_err_overflow, r_err_overrun;
   logic             w_set_timeout, w_set_overflow, w_set_overrun;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_sck_s1 <= 1'b0;
         r_sck_s2 <= 1'b0;
         r_sck_s3 <= 1'b0;
         r_sd_s1  <= 1'b0;
         r_sd_s2  <= 1'b0;
      end else begin
         r_sck_s1 <= bus.serial_clock_raw;
         r_sck_s2 <= r_sck_s1;
         r_sck_s3 <= r_sck_s2;
         r_sd_s1  <= bus.serial_data_raw;
         r_sd_s2  <= r_sd_s1;
      end
   end

   assign w_edge = r_sck_s2 & ~r_sck_s3;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= S_FLUSH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Exit checks outrank the edge; an edge coinciding with any exit is not shifted.
   always_comb begin
      w_state_nxt    = r_state;
      w_strobe_nxt   = 1'b0;
      w_bit_cnt_nxt  = r_bit_count;
      w_gap_nxt      = r_gap;
      w_set_timeout  = 1'b0;
      w_set_overflow = 1'b0;
      w_set_overrun  = 1'b0;
      case (r_state)
         S_FLUSH: begin
            w_bit_cnt_nxt = '0;
            w_gap_nxt     = '0;
            w_state_nxt   = S_IDLE;
         end
         S_IDLE: begin
            w_gap_nxt = '0;
            if (w_edge) begin
               w_strobe_nxt  = 1'b1;
               w_bit_cnt_nxt = CNT_W'(1);
               w_state_nxt   = S_RECEIVE;
            end
         end
         S_RECEIVE: begin
            if (bus.decoder_valid && (r_bit_count >= CNT_W'(FRAME_BITS))) begin
               w_set_overrun = w_edge;
               w_state_nxt   = S_HOLD;
            end else if (r_gap == GAP_W'(GAP_CYCLES - 1)) begin
               w_set_timeout = 1'b1;
               w_state_nxt   = S_FLUSH;
            end else if (r_bit_count == CNT_W'(MAX_BITS)) begin
               w_set_overflow = 1'b1;
               w_state_nxt    = S_FLUSH;
            end else if (w_edge && !bus.decoder_valid) begin
               w_strobe_nxt  = 1'b1;
               w_bit_cnt_nxt = r_bit_count + 1'b1;
               w_gap_nxt     = '0;
            end else begin
               w_gap_nxt = r_gap + 1'b1;
            end
         end
         S_HOLD: begin
            w_set_overrun = w_edge;
            if (bus.frame_ack) begin
               w_state_nxt = S_FLUSH;
            end
         end
         default: w_state_nxt = S_FLUSH;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_shift_strobe <= 1'b0;
         r_shift_data   <= 1'b0;
         r_bit_count    <= '0;
         r_gap          <= '0;
         r_err_timeout  <= 1'b0;
         r_err_overflow <= 1'b0;
         r_err_overrun  <= 1'b0;
      end else begin
         r_shift_strobe <= w_strobe_nxt;
         if (w_strobe_nxt) begin
            r_shift_data <= r_sd_s2;
         end
         r_bit_count    <= w_bit_cnt_nxt;
         r_gap          <= w_gap_nxt;
         r_err_timeout  <= r_err_timeout  | w_set_timeout;
         r_err_overflow <= r_err_overflow | w_set_overflow;
         r_err_overrun  <= r_err_overrun  | w_set_overrun;
      end
   end

   assign bus.shift_strobe  = r_shift_strobe;
   assign bus.shift_data    = r_shift_data;
   assign bus.decoder_clear = (r_state == S_FLUSH);
   assign bus.frame_ready   = (r_state == S_HOLD);
   assign bus.bit_count     = r_bit_count;
   assign bus.err_timeout   = r_err_timeout;
   assign bus.err_overflow  = r_err_overflow;
   assign bus.err_overrun   = r_err_overrun;

`ifdef FRAME_COUNTER_EN
   logic [7:0] r_frame_count;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_frame_count <= '0;
      end else if ((r_state == S_HOLD) && bus.frame_ack) begin
         r_frame_count <= r_frame_count + 1'b1;
      end
   end

   assign bus.frame_count = r_frame_count;
`else
   assign bus.frame_count = '0;
`endif

endmodule

// File: tb/tb_bep_frame_sequencer.sv
// Directed bench for bep_frame_sequencer: frame capture, timeout, overflow, overrun, partial valid, reset.
// Inputs change on falling clock edges; outputs are sampled on falling edges or #1 after async reset.
module tb_bep_frame_sequencer;
   localparam int unsigned FRAME_BITS = 192;
   localparam int unsigned MAX_BITS   = 1024;
   localparam int unsigned GAP_CYCLES = 4096;
   localparam int unsigned CNT_W      = 11;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   int unsigned  n_total = 0;
   int unsigned  n_bad = 0;
   int unsigned  n_strobes = 0;
   int unsigned  n_ready = 0;
   int unsigned  exp_frames = 0;
   int unsigned  snap;
   logic [191:0] ref_frame;

   bep_frame_sequencer_if #(.CNT_W(CNT_W)) bus ();

   bep_frame_sequencer #(
      .FRAME_BITS (FRAME_BITS),
      .MAX_BITS   (MAX_BITS),
      .GAP_CYCLES (GAP_CYCLES),
      .CNT_W      (CNT_W)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      #1;
      if (bus.shift_strobe) n_strobes++;
      if (bus.frame_ready) n_ready++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int unsigned exp_fc();
`ifdef FRAME_COUNTER_EN
      return exp_frames % 256;
`else
      return 0;
`endif
   endfunction

   // One serial bit, 16 clocks long; strobe expected exactly 3 clocks after the raw rise.
   task automatic send_bit(input logic b, input logic exp_strobe);
      bus.serial_data_raw  = b;
      bus.serial_clock_raw = 1'b1;
      repeat (2) @(negedge clock);
      chk("strobe_early", 32'(bus.shift_strobe), 0);
      @(negedge clock);
      chk("strobe", 32'(bus.shift_strobe), 32'(exp_strobe));
      if (exp_strobe) chk("shift_data", 32'(bus.shift_data), 32'(b));
      @(negedge clock);
      chk("strobe_width", 32'(bus.shift_strobe), 0);
      repeat (4) @(negedge clock);
      bus.serial_clock_raw = 1'b0;
      repeat (8) @(negedge clock);
   endtask

   task automatic send_range(input int first, input int last);
      for (int k = first; k < last; k++) send_bit(ref_frame[191 - (k % 192)], 1'b1);
   endtask

   task automatic enter_hold();
      bus.decoder_valid = 1'b1;
      @(negedge clock);
      bus.decoder_valid = 1'b0;
      chk("hold_ready", 32'(bus.frame_ready), 1);
      chk("hold_clear", 32'(bus.decoder_clear), 0);
      chk("hold_bit_count", 32'(bus.bit_count), 192);
   endtask

   task automatic do_ack();
      bus.frame_ack = 1'b1;
      @(negedge clock);
      bus.frame_ack = 1'b0;
      exp_frames++;
      chk("ack_ready_drop", 32'(bus.frame_ready), 0);
      chk("ack_clear", 32'(bus.decoder_clear), 1);
      chk("frame_count", 32'(bus.frame_count), exp_fc());
      @(negedge clock);
      chk("ack_clear_one", 32'(bus.decoder_clear), 0);
      chk("ack_bit_count", 32'(bus.bit_count), 0);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_clear"}, 32'(bus.decoder_clear), 1);
      chk({tag, "_strobe"}, 32'(bus.shift_strobe), 0);
      chk({tag, "_data"}, 32'(bus.shift_data), 0);
      chk({tag, "_ready"}, 32'(bus.frame_ready), 0);
      chk({tag, "_bit_count"}, 32'(bus.bit_count), 0);
      chk({tag, "_timeout"}, 32'(bus.err_timeout), 0);
      chk({tag, "_overflow"}, 32'(bus.err_overflow), 0);
      chk({tag, "_overrun"}, 32'(bus.err_overrun), 0);
      chk({tag, "_frame_count"}, 32'(bus.frame_count), 0);
   endtask

   initial begin
      ref_frame = {64'hDEAD_BEEF_0123_4567, 64'h89AB_CDEF_F0E1_D2C3, 64'h5A5A_3C3C_0FF0_9669};
      bus.serial_clock_raw = 1'b0;
      bus.serial_data_raw  = 1'b0;
      bus.decoder_valid    = 1'b0;
      bus.frame_ack        = 1'b0;

      // Reset and release: one FLUSH cycle, then IDLE
      repeat (3) @(negedge clock);
      chk_reset_values("rst");
      reset = 1'b1;
      #1;
      chk("rel_clear", 32'(bus.decoder_clear), 1);
      @(negedge clock);
      chk("rel_clear_one", 32'(bus.decoder_clear), 0);

      // Reference frame
      snap = n_strobes;
      send_range(0, 192);
      chk("frame_strobes", n_strobes - snap, 192);
      chk("frame_bit_count", 32'(bus.bit_count), 192);
      chk("frame_not_ready", 32'(bus.frame_ready), 0);
      enter_hold();
      do_ack();
      chk("frame_no_overrun", 32'(bus.err_overrun), 0);

      // Gap timeout after 50 bits
      snap = n_ready;
      send_range(0, 50);
      chk("to_bit_count", 32'(bus.bit_count), 50);
      repeat (GAP_CYCLES - 14) @(negedge clock);
      chk("to_early", 32'(bus.err_timeout), 0);
      @(negedge clock);
      chk("to_set", 32'(bus.err_timeout), 1);
      chk("to_flush", 32'(bus.decoder_clear), 1);
      @(negedge clock);
      chk("to_bit_count_clr", 32'(bus.bit_count), 0);
      chk("to_idle", 32'(bus.decoder_clear), 0);
      chk("to_never_ready", n_ready - snap, 0);

      // Overflow at MAX_BITS without valid, then normal frame
      send_range(0, MAX_BITS - 1);
      chk("ovf_bit_count", 32'(bus.bit_count), MAX_BITS - 1);
      chk("ovf_early", 32'(bus.err_overflow), 0);
      send_range(MAX_BITS - 1, MAX_BITS);
      chk("ovf_set", 32'(bus.err_overflow), 1);
      chk("ovf_bit_count_clr", 32'(bus.bit_count), 0);
      chk("ovf_never_ready", n_ready - snap, 0);
      chk("ovf_timeout_sticky", 32'(bus.err_timeout), 1);
      send_range(0, 192);
      enter_hold();
      do_ack();

      // Edges during HOLD
      send_range(0, 192);
      enter_hold();
      snap = n_strobes;
      repeat (3) send_bit(1'b1, 1'b0);
      chk("ovr_strobes", n_strobes - snap, 0);
      chk("ovr_set", 32'(bus.err_overrun), 1);
      chk("ovr_ready", 32'(bus.frame_ready), 1);
      chk("ovr_bit_count", 32'(bus.bit_count), 192);
      do_ack();

      // Early valid pulse at bit 100 is ignored
      send_range(0, 100);
      bus.decoder_valid = 1'b1;
      @(negedge clock);
      bus.decoder_valid = 1'b0;
      chk("part_not_ready", 32'(bus.frame_ready), 0);
      chk("part_bit_count", 32'(bus.bit_count), 100);
      @(negedge clock);
      chk("part_still_rx", 32'(bus.frame_ready), 0);
      send_range(100, 192);
      enter_hold();
      do_ack();

      // Asynchronous reset mid-frame
      send_range(0, 20);
      chk("mid_bit_count", 32'(bus.bit_count), 20);
      reset = 1'b0;
      #1;
      exp_frames = 0;
      chk_reset_values("mid");
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("mid_rel_clear", 32'(bus.decoder_clear), 1);
      @(negedge clock);
      chk("mid_rel_clear_one", 32'(bus.decoder_clear), 0);
      chk("mid_frame_count", 32'(bus.frame_count), exp_fc());

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
